microprogram_sequencer: RTL and testbench
=========================================

# microprogram_sequencer

Next-microaddress sequencer for the control unit. It selects one of four status conditions (memory operation complete, branch condition, branch annul, trap), optionally inverts it, and computes the next microprogram counter from the current microword's next-address field. It supports a one-level subroutine return register and a memory-wait state with timeout. It drives the control-store address every cycle and sits between the control ROM output fields and the control ROM address input.

## Interface
Parameters:
- ADDR_W, 7, microaddress width (control store of 2^ADDR_W words)
- RESET_VECTOR, 0, microaddress loaded on reset
- TRAP_VECTOR, 7'h7F, microaddress forced on memory-wait timeout
- TIMEOUT, 16, maximum consecutive cycles a WAIT may hold (range 0–255); 0 disables the timeout

Ports:
- Clk  in  1  single clock; all state updates on the rising edge
- Reset_n  in  1  **asynchronous, active-low reset**
- Memory_Operation_Complete  in  1  condition source 0
- Branch_Condition  in  1  condition source 1
- Branch_Annul  in  1  condition source 2
- Trap  in  1  condition source 3
- Condition_Select  in  2  microword field choosing condition source 0–3
- Invert  in  1  microword field; 1 inverts the selected condition
- Next_Select  in  3  microword next-address field (encoding below)
- Target  in  ADDR_W  microword jump/call target
- Dispatch_Address  in  ADDR_W  opcode-decoder entry address
- Hold  in  1  freezes all sequencer state
- uPC  out  ADDR_W  registered current microaddress to the control store
- Condition  out  1  selected condition XOR Invert (combinational)
- Stalled  out  1  registered; 1 while a WAIT is holding
- Memory_Timeout  out  1  registered one-cycle pulse on timeout

## Operation
- **Condition (cond):** the source chosen by Condition_Select, XOR Invert.
- **Next_Select encodings.** "inc" means (uPC+1) mod 2^ADDR_W:
  - 000 INC: next = inc
  - 001 JUMP: next = Target
  - 010 CJUMP: next = cond ? Target : inc
  - 011 DISPATCH: next = Dispatch_Address
  - 100 CALL: Ret_Reg ← inc; next = Target
  - 101 RET: next = Ret_Reg
  - 110 WAIT: cond ? inc : uPC (hold)
  - 111 reserved: behaves as INC
- **Ret_Reg:** internal ADDR_W register, one level deep. A nested CALL overwrites it. RET without a prior CALL returns to RESET_VECTOR.
- **Wait counter:** internal 8-bit counter.
  - Increments each edge on which a WAIT holds.
  - Clears whenever the WAIT is not holding (cond true, or a different Next_Select).
- **Timeout:** when TIMEOUT≠0, a WAIT is holding and the counter equals TIMEOUT−1, the next edge does all of the following instead of holding:
  - uPC ← TRAP_VECTOR
  - Memory_Timeout ← 1
  - counter ← 0
  - Stalled ← 0
- **Priority within one edge:** Hold > timeout > Next_Select decode.
- **Hold=1:** uPC, Ret_Reg, counter, Stalled and Memory_Timeout all keep their values. Exception: Memory_Timeout still clears to 0, so the pulse stays one cycle long.
- **Stalled:** registered as 1 on any edge where the WAIT holds without timing out; 0 otherwise.
- **Reset (Reset_n low), at any time including mid-WAIT:** immediately sets uPC=RESET_VECTOR, Ret_Reg=RESET_VECTOR, counter=0, Stalled=0, Memory_Timeout=0. Operation resumes on the first rising edge after deassertion.

## Timing
- uPC is registered. The next address is combinational from the current microword fields and the condition inputs; there is one cycle of latency from microword to new uPC.
- Condition is combinational with zero latency; the condition inputs must be stable before the edge.
- A WAIT entered at edge N with cond held false and TIMEOUT=16 holds through edges N+1…N+15. At edge N+16 the sequencer vectors to TRAP_VECTOR, and Memory_Timeout is high for exactly that cycle.
- A WAIT whose cond becomes true advances on that same edge, and Stalled drops on that edge.
- Increment wraps: uPC=2^ADDR_W−1 with INC gives 0. CALL at the top address saves 0.
- DISPATCH, CALL and JUMP ignore cond.

## Test plan
- **Reset/wrap:** assert Reset_n=0 mid-run → uPC=0, Stalled=0, Memory_Timeout=0 immediately. Release, then INC from uPC=127 → uPC=0.
- **CJUMP with invert:** Condition_Select=01, Branch_Condition=1, Target=0x40.
  - Invert=0 → uPC=0x40.
  - Invert=1 → uPC=inc.
  - Condition output matches in both cases.
- **CALL/RET:** at uPC=0x10, CALL Target=0x50 → uPC=0x50. Then RET → uPC=0x11. A nested CALL from 0x50 to 0x60 followed by RET → uPC=0x51.
- **WAIT completion:** WAIT, Condition_Select=00, Memory_Operation_Complete rises after 3 cycles → uPC held 3 cycles with Stalled=1, then advances to inc. Counter clears; no timeout.
- **WAIT timeout:** Memory_Operation_Complete held at 0 → after 16 edges uPC=0x7F, Memory_Timeout=1 for one cycle, Stalled=0.
- **Hold mid-WAIT:** after 5 waiting cycles, raise Hold for 20 cycles → no timeout and uPC unchanged. Release → timeout occurs 11 edges later.

Source files
------------

// File: rtl/microprogram_sequencer.sv
// rtl/microprogram_sequencer.sv - next-microaddress sequencer with call/return and memory-wait timeout
module microprogram_sequencer #(
    parameter int                ADDR_W       = 7,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(7'h7F),
    parameter int                TIMEOUT      = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Memory_Operation_Complete,
    input  logic              Branch_Condition,
    input  logic              Branch_Annul,
    input  logic              Trap,
    input  logic [1:0]        Condition_Select,
    input  logic              Invert,
    input  logic [2:0]        Next_Select,
    input  logic [ADDR_W-1:0] Target,
    input  logic [ADDR_W-1:0] Dispatch_Address,
    input  logic              Hold,
    output logic [ADDR_W-1:0] uPC,
    output logic              Condition,
    output logic              Stalled,
    output logic              Memory_Timeout
);

    localparam logic [2:0] NS_INC      = 3'b000;
    localparam logic [2:0] NS_JUMP     = 3'b001;
    localparam logic [2:0] NS_CJUMP    = 3'b010;
    localparam logic [2:0] NS_DISPATCH = 3'b011;
    localparam logic [2:0] NS_CALL     = 3'b100;
    localparam logic [2:0] NS_RET      = 3'b101;
    localparam logic [2:0] NS_WAIT     = 3'b110;

    // Counter value at which the next holding edge vectors to the trap instead
    localparam logic [7:0] WAIT_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [ADDR_W-1:0] ret_q, ret_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              stalled_q, stalled_d;
    logic              mto_q, mto_d;
    logic              cond_src;
    logic              cond;
    logic              waiting;
    logic              timeout_hit;
    logic [ADDR_W-1:0] inc;

    always_comb begin
        cond_src = 1'b0;
        case (Condition_Select)
            2'd0:    cond_src = Memory_Operation_Complete;
            2'd1:    cond_src = Branch_Condition;
            2'd2:    cond_src = Branch_Annul;
            default: cond_src = Trap;
        endcase
    end

    assign cond        = cond_src ^ Invert;
    assign inc         = upc_q + 1'b1;
    assign waiting     = (Next_Select == NS_WAIT) && !cond;
    assign timeout_hit = (TIMEOUT != 0) && waiting && (cnt_q == WAIT_LAST);

    always_comb begin
        upc_d     = upc_q;
        ret_d     = ret_q;
        cnt_d     = cnt_q;
        stalled_d = stalled_q;
        mto_d     = 1'b0;
        if (Hold) begin
            // Everything freezes except the timeout pulse, which must stay one cycle wide
            mto_d = 1'b0;
        end else if (timeout_hit) begin
            upc_d     = TRAP_VECTOR;
            mto_d     = 1'b1;
            cnt_d     = 8'd0;
            stalled_d = 1'b0;
        end else begin
            stalled_d = waiting;
            cnt_d     = waiting ? cnt_q + 8'd1 : 8'd0;
            case (Next_Select)
                NS_JUMP:     upc_d = Target;
                NS_CJUMP:    upc_d = cond ? Target : inc;
                NS_DISPATCH: upc_d = Dispatch_Address;
                NS_CALL: begin
                    ret_d = inc;
                    upc_d = Target;
                end
                NS_RET:      upc_d = ret_q;
                NS_WAIT:     upc_d = cond ? inc : upc_q;
                default:     upc_d = inc;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            upc_q     <= RESET_VECTOR;
            ret_q     <= RESET_VECTOR;
            cnt_q     <= 8'd0;
            stalled_q <= 1'b0;
            mto_q     <= 1'b0;
        end else begin
            upc_q     <= upc_d;
            ret_q     <= ret_d;
            cnt_q     <= cnt_d;
            stalled_q <= stalled_d;
            mto_q     <= mto_d;
        end
    end

    assign uPC            = upc_q;
    assign Condition      = cond;
    assign Stalled        = stalled_q;
    assign Memory_Timeout = mto_q;

endmodule

// File: tb/tb_microprogram_sequencer.sv
// tb/tb_microprogram_sequencer.sv - directed self-checking bench for microprogram_sequencer
module tb_microprogram_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Memory_Operation_Complete;
    logic       Branch_Condition;
    logic       Branch_Annul;
    logic       Trap;
    logic [1:0] Condition_Select;
    logic       Invert;
    logic [2:0] Next_Select;
    logic [6:0] Target;
    logic [6:0] Dispatch_Address;
    logic       Hold;
    logic [6:0] uPC;
    logic       Condition;
    logic       Stalled;
    logic       Memory_Timeout;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    microprogram_sequencer #(
        .ADDR_W      (7),
        .RESET_VECTOR(7'h00),
        .TRAP_VECTOR (7'h7F),
        .TIMEOUT     (16)
    ) dut (
        .Clk                      (Clk),
        .Reset_n                  (Reset_n),
        .Memory_Operation_Complete(Memory_Operation_Complete),
        .Branch_Condition         (Branch_Condition),
        .Branch_Annul             (Branch_Annul),
        .Trap                     (Trap),
        .Condition_Select         (Condition_Select),
        .Invert                   (Invert),
        .Next_Select              (Next_Select),
        .Target                   (Target),
        .Dispatch_Address         (Dispatch_Address),
        .Hold                     (Hold),
        .uPC                      (uPC),
        .Condition                (Condition),
        .Stalled                  (Stalled),
        .Memory_Timeout           (Memory_Timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic mw(input logic [2:0] ns, input logic [6:0] tgt);
        Next_Select = ns;
        Target      = tgt;
    endtask

    initial begin
        Reset_n = 1'b0;
        Memory_Operation_Complete = 1'b0;
        Branch_Condition = 1'b0;
        Branch_Annul = 1'b0;
        Trap = 1'b0;
        Condition_Select = 2'd0;
        Invert = 1'b0;
        Next_Select = 3'b000;
        Target = 7'h00;
        Dispatch_Address = 7'h00;
        Hold = 1'b0;

        step();
        step();
        chk("reset_upc", uPC, 7'h00);
        chk("reset_stalled", Stalled, 1'b0);
        chk("reset_mto", Memory_Timeout, 1'b0);
        Reset_n = 1'b1;

        mw(3'b000, 7'h00); step(); chk("inc_first", uPC, 7'h01);
        mw(3'b101, 7'h00); step(); chk("ret_no_call", uPC, 7'h00);
        mw(3'b001, 7'h7F); step(); chk("jump_top", uPC, 7'h7F);
        mw(3'b000, 7'h00); step(); chk("inc_wrap", uPC, 7'h00);
        mw(3'b001, 7'h7F); step();
        mw(3'b100, 7'h20); step(); chk("call_top", uPC, 7'h20);
        mw(3'b101, 7'h00); step(); chk("ret_top_saved0", uPC, 7'h00);

        Condition_Select = 2'd1; Branch_Condition = 1'b1; Invert = 1'b0;
        mw(3'b010, 7'h40);
        #1 chk("cond_noinv", Condition, 1'b1);
        step(); chk("cjump_taken", uPC, 7'h40);
        Invert = 1'b1;
        #1 chk("cond_inv", Condition, 1'b0);
        step(); chk("cjump_not_taken", uPC, 7'h41);

        Invert = 1'b0; Condition_Select = 2'd3; Trap = 1'b1;
        mw(3'b010, 7'h05); step(); chk("cjump_trap_src", uPC, 7'h05);
        Trap = 1'b0; step(); chk("cjump_trap_low", uPC, 7'h06);

        mw(3'b001, 7'h10); step(); chk("jump_10", uPC, 7'h10);
        mw(3'b100, 7'h50); step(); chk("call_50", uPC, 7'h50);
        mw(3'b101, 7'h00); step(); chk("ret_11", uPC, 7'h11);
        mw(3'b100, 7'h50); step(); chk("call_50b", uPC, 7'h50);
        mw(3'b100, 7'h60); step(); chk("nested_call_60", uPC, 7'h60);
        mw(3'b101, 7'h00); step(); chk("nested_ret_51", uPC, 7'h51);

        Condition_Select = 2'd1; Branch_Condition = 1'b0; Dispatch_Address = 7'h33;
        mw(3'b011, 7'h00); step(); chk("dispatch", uPC, 7'h33);
        mw(3'b111, 7'h00); step(); chk("reserved_inc", uPC, 7'h34);

        Condition_Select = 2'd0; Memory_Operation_Complete = 1'b0;
        mw(3'b110, 7'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_hold_upc", uPC, 7'h34);
            chk("wait_hold_stalled", Stalled, 1'b1);
        end
        Memory_Operation_Complete = 1'b1;
        step();
        chk("wait_done_upc", uPC, 7'h35);
        chk("wait_done_stalled", Stalled, 1'b0);
        chk("wait_done_mto", Memory_Timeout, 1'b0);

        Memory_Operation_Complete = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_hold_upc", uPC, 7'h35);
            chk("to_hold_mto", Memory_Timeout, 1'b0);
        end
        chk("to_hold_stalled", Stalled, 1'b1);
        step();
        chk("to_upc", uPC, 7'h7F);
        chk("to_mto", Memory_Timeout, 1'b1);
        chk("to_stalled", Stalled, 1'b0);
        Hold = 1'b1;
        step();
        chk("hold_clears_mto", Memory_Timeout, 1'b0);
        chk("hold_keeps_upc", uPC, 7'h7F);
        Hold = 1'b0;
        mw(3'b001, 7'h08); step(); chk("jump_08", uPC, 7'h08);

        mw(3'b110, 7'h00);
        for (int i = 0; i < 5; i++) step();
        Hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_wait_upc", uPC, 7'h08);
            chk("hold_wait_mto", Memory_Timeout, 1'b0);
        end
        chk("hold_wait_stalled", Stalled, 1'b1);
        Hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_hold_upc", uPC, 7'h08);
            chk("post_hold_mto", Memory_Timeout, 1'b0);
        end
        step();
        chk("post_hold_to_upc", uPC, 7'h7F);
        chk("post_hold_to_mto", Memory_Timeout, 1'b1);

        mw(3'b001, 7'h20); step(); chk("jump_20", uPC, 7'h20);
        mw(3'b110, 7'h00);
        for (int i = 0; i < 3; i++) step();
        chk("pre_reset_stalled", Stalled, 1'b1);
        Reset_n = 1'b0;
        #1;
        chk("async_reset_upc", uPC, 7'h00);
        chk("async_reset_stalled", Stalled, 1'b0);
        chk("async_reset_mto", Memory_Timeout, 1'b0);
        step();
        Reset_n = 1'b1;
        mw(3'b000, 7'h00); step(); chk("resume_inc", uPC, 7'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
